spi_gpio_expander: RTL

//  Parametrised SPI-slave GPIO/PWM expander: an external host reads and writes a

---
 rtl/spi_gpio_expander.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_gpio_expander.sv
// rtl/spi_gpio_expander.sv - SPI mode-0 slave register file driving GPIO/PWM channels
`timescale 1ns/1ps
module spi_gpio_expander #(
    parameter int N_CH     = 4,
    parameter int PWM_BITS = 6,
    parameter int PWM_DIV  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            spi_sclk,
    input  logic            spi_cs_n,
    input  logic            spi_mosi,
    output logic            spi_miso,
    input  logic [N_CH-1:0] gpio_in,
    output logic [N_CH-1:0] gpio_out,
    output logic [N_CH-1:0] gpio_oe
);
    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;
    state_t state, state_nxt;

    // cs_n flops reset low so a cs_n held low through reset cannot start a frame
    logic [1:0]      sclk_sync, cs_sync, mosi_sync;
    logic            sclk_q, cs_q;
    logic [N_CH-1:0] in_m, in_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
            in_m      <= '0;
            in_s      <= '0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sclk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_q    <= sclk_sync[1];
            cs_q      <= cs_sync[1];
            in_m      <= gpio_in;
            in_s      <= in_m;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_s, mosi_s;
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;

    logic [6:0] shift_r;
    logic [2:0] bit_cnt;
    logic [7:0] addr, tx_r, rx_byte, rd_addr, rd_data;
    logic       is_read, byte_done, wr_en;

    logic [3:0]          ctrl    [N_CH];
    logic [PWM_BITS-1:0] duty    [N_CH];
    logic [PWM_BITS-1:0] duty_sh [N_CH];
    logic                out_r   [N_CH];

    assign rx_byte   = {shift_r, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE) && !cs_s;
    assign wr_en     = byte_done && (state == DATA) && !is_read;
    assign rd_addr   = (state == ADDR) ? rx_byte : addr + 8'd1;
    assign spi_miso  = (state == DATA) && is_read && tx_r[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (cs_fall) state_nxt = CMD;
        end else if (cs_s) begin
            state_nxt = IDLE;
        end else if (byte_done) begin
            case (state)
                CMD:     state_nxt = ADDR;
                ADDR:    state_nxt = DATA;
                default: state_nxt = DATA;
            endcase
        end
    end

    // Addresses past the last channel match no loop index and read as zero
    always_comb begin
        rd_data = 8'h00;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_addr[7:2] == 6'(c)) begin
                case (rd_addr[1:0])
                    2'd0:    rd_data = {4'b0, ctrl[c]};
                    2'd1:    rd_data = 8'(duty[c]);
                    2'd2:    rd_data = {7'b0, out_r[c]};
                    default: rd_data = {7'b0, in_s[c]};
                endcase
            end
        end
    end

    // tx shifts only on falls inside a data byte, so bit7 stays up until the first data rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            bit_cnt <= '0;
            addr    <= '0;
            tx_r    <= '0;
            is_read <= 1'b0;
        end else if (state == IDLE || cs_s) begin
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            shift_r <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
                case (state)
                    CMD:  is_read <= rx_byte[7];
                    ADDR: begin
                        addr <= rx_byte;
                        if (is_read) tx_r <= rd_data;
                    end
                    default: begin
                        addr <= addr + 8'd1;
                        if (is_read) tx_r <= rd_data;
                    end
                endcase
            end
        end else if (sclk_fall && state == DATA && bit_cnt != 3'd0) begin
            tx_r <= {tx_r[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                ctrl[c]  <= '0;
                duty[c]  <= '0;
                out_r[c] <= 1'b0;
            end
        end else if (wr_en) begin
            for (int c = 0; c < N_CH; c++) begin
                if (addr[7:2] == 6'(c)) begin
                    case (addr[1:0])
                        2'd0:    ctrl[c]  <= rx_byte[3:0];
                        2'd1:    duty[c]  <= rx_byte[PWM_BITS-1:0];
                        2'd2:    out_r[c] <= rx_byte[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_step;
    assign pwm_step = (div_cnt == DIV_W'(PWM_DIV - 1));

    // Shadow duty reloads only at counter wrap so a period is never cut short
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
            for (int c = 0; c < N_CH; c++) duty_sh[c] <= '0;
        end else begin
            div_cnt <= pwm_step ? '0 : div_cnt + 1'b1;
            if (pwm_step) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (&pwm_cnt) begin
                    for (int c = 0; c < N_CH; c++) duty_sh[c] <= duty[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                gpio_out[c] <= ctrl[c][0] &
                               ((ctrl[c][2] ? (pwm_cnt < duty_sh[c]) : out_r[c]) ^ ctrl[c][3]);
                gpio_oe[c]  <= ctrl[c][0] & ctrl[c][1];
            end
        end
    end
endmodule
